// File: rtl/demux_switchover_ctrl.sv
// Packet-safe demux select sequencer: drains the in-flight packet, closes the gate, swaps select, reopens.
// Latency: idle switch completes in 4 cycles (DRAIN, SWITCH, GUARD, then IDLE with done).
// Backpressure: cmd_ready low while busy; stream gate passes m_tready/s_tvalid only in IDLE or mid-packet.
module demux_switchover_ctrl #(
    parameter int M_COUNT    = 2,
    parameter int CL_M_COUNT = $clog2(M_COUNT),
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  axil_aclk,
    input  logic                  axil_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CL_M_COUNT-1:0] cmd_select,
    input  logic [TIMEOUT_W-1:0]  cmd_timeout,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [CL_M_COUNT-1:0] select_active,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_range,
    output logic [15:0]           switch_count
);

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, GUARD} state_t;

    state_t                  state, state_nxt;
    logic                    in_pkt;
    logic                    gate_open;
    logic                    hs;
    logic                    cmd_acc;
    logic                    sel_oob;
    logic [CL_M_COUNT-1:0]   pend_sel;
    logic [TIMEOUT_W-1:0]    timer;
    logic [TIMEOUT_W-1:0]    timer_dec;
    logic                    done_nxt;
    logic                    err_timeout_nxt;
    logic                    err_range_nxt;
    logic                    load_cmd;
    logic                    apply_sel;
    logic                    timer_tick;

    assign gate_open = (state == IDLE) || in_pkt;
    assign m_tvalid  = s_tvalid && gate_open;
    assign s_tready  = m_tready && gate_open;
    assign hs        = m_tvalid && m_tready;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign sel_oob   = 32'(cmd_select) >= M_COUNT;
    assign timer_dec = timer - TIMEOUT_W'(1);

    always_comb begin
        state_nxt       = state;
        done_nxt        = 1'b0;
        err_timeout_nxt = 1'b0;
        err_range_nxt   = 1'b0;
        load_cmd        = 1'b0;
        apply_sel       = 1'b0;
        timer_tick      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (sel_oob) begin
                        err_range_nxt = 1'b1;
                    end else if (cmd_select == select_active) begin
                        done_nxt = 1'b1;
                    end else begin
                        load_cmd  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!in_pkt) begin
                    state_nxt = SWITCH;
                end else begin
                    // A zero timer means wait forever; expiry beats a coincident tlast.
                    timer_tick = (timer != '0);
                    if (timer_tick && (timer_dec == '0)) begin
                        state_nxt       = IDLE;
                        err_timeout_nxt = 1'b1;
                    end else if (hs && s_tlast) begin
                        state_nxt = SWITCH;
                    end
                end
            end
            SWITCH: begin
                apply_sel = 1'b1;
                state_nxt = GUARD;
            end
            GUARD: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axil_aclk or posedge axil_areset) begin
        if (axil_areset) begin
            state         <= IDLE;
            in_pkt        <= 1'b0;
            pend_sel      <= '0;
            timer         <= '0;
            select_active <= '0;
            switch_count  <= '0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            err_range     <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= done_nxt;
            err_timeout <= err_timeout_nxt;
            err_range   <= err_range_nxt;
            if (hs) begin
                in_pkt <= !s_tlast;
            end
            if (load_cmd) begin
                pend_sel <= cmd_select;
                timer    <= cmd_timeout;
            end else if (timer_tick) begin
                timer <= timer_dec;
            end
            if (apply_sel) begin
                select_active <= pend_sel;
                switch_count  <= switch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_switchover_ctrl.sv
// Bench for demux_switchover_ctrl: per-scenario tasks with inline checks plus a per-beat port scoreboard.
module tb_demux_switchover_ctrl;

    localparam int CL = 2;
    localparam int TW = 16;

    logic          axil_aclk = 1'b0;
    logic          axil_areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CL-1:0] cmd_select;
    logic [TW-1:0] cmd_timeout;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [CL-1:0] select_active;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_range;
    logic [15:0]   switch_count;

    demux_switchover_ctrl #(.M_COUNT(2), .CL_M_COUNT(CL), .TIMEOUT_W(TW)) dut (
        .axil_aclk    (axil_aclk),
        .axil_areset  (axil_areset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_select   (cmd_select),
        .cmd_timeout  (cmd_timeout),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .select_active(select_active),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_range    (err_range),
        .switch_count (switch_count)
    );

    always #5 axil_aclk = ~axil_aclk;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            beats_seen = 0;
    int            sel_chg_cyc = -1;
    int            done_cyc = -1;
    int            tlast_cyc = -1;
    logic [CL-1:0] exp_q[$];
    logic [CL-1:0] exp_pt;
    logic [CL-1:0] prev_sel = '0;

    always @(posedge axil_aclk) cyc++;

    // Scoreboard: each accepted beat must leave on the port expected when it was queued.
    always @(negedge axil_aclk) begin
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: beat on port %0d at cycle %0d, none expected", select_active, cyc);
            end else begin
                exp_pt = exp_q.pop_front();
                if (select_active !== exp_pt || s_tready !== 1'b1) begin
                    fails++;
                    $display("FAIL beat_port: got port %0d s_tready %b, want port %0d s_tready 1", select_active, s_tready, exp_pt);
                end
            end
            beats_seen++;
        end
        if (select_active !== prev_sel) sel_chg_cyc = cyc;
        prev_sel = select_active;
        if (done === 1'b1) done_cyc = cyc;
        if ((done | err_timeout | err_range) === 1'b1) begin
            tests++;
            if (32'(done) + 32'(err_timeout) + 32'(err_range) != 1) begin
                fails++;
                $display("FAIL pulse_exclusive: done %b err_timeout %b err_range %b, want exactly one", done, err_timeout, err_range);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge axil_aclk);
        #1;
    endtask

    task automatic do_reset();
        axil_areset = 1'b1;
        cmd_valid   = 1'b0;
        cmd_select  = '0;
        cmd_timeout = '0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        m_tready    = 1'b0;
        repeat (2) @(posedge axil_aclk);
        #1;
        axil_areset = 1'b0;
        exp_q.delete();
        nxt();
    endtask

    // Returns in the window of the cycle after acceptance.
    task automatic issue_cmd(input logic [CL-1:0] sel, input logic [TW-1:0] to, output int acc);
        int n = 0;
        cmd_valid   = 1'b1;
        cmd_select  = sel;
        cmd_timeout = to;
        while (cmd_ready !== 1'b1 && n < 50) begin
            nxt();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: cmd_ready stayed %b for 50 cycles, want 1", cmd_ready);
        end
        acc = cyc;
        nxt();
        cmd_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [CL-1:0] port, input bit with_last);
        logic acc;
        int   n;
        for (int i = 0; i < len; i++) exp_q.push_back(port);
        for (int i = 0; i < len; i++) begin
            s_tvalid = 1'b1;
            s_tlast  = with_last && (i == len - 1);
            n = 0;
            do begin
                @(negedge axil_aclk);
                acc = m_tvalid && m_tready;
                nxt();
                n++;
            end while (!acc && n < 100);
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL send_beat: beat %0d not accepted within 100 cycles", i);
            end
            if (s_tlast) tlast_cyc = cyc - 1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        axil_areset = 1'b1;
        cmd_valid   = 1'b0;
        cmd_select  = '0;
        cmd_timeout = '0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        m_tready    = 1'b0;
        #2;
        tests++;
        if ({busy, done, err_timeout, err_range, cmd_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_flags: busy,done,err_t,err_r,cmd_ready = %b, want 00001",
                     {busy, done, err_timeout, err_range, cmd_ready});
        end
        tests++;
        if (select_active !== 2'd0 || switch_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_regs: select %0d count %0d, want 0 0", select_active, switch_count);
        end
        do_reset();
    endtask

    task automatic test_idle_switch();
        int         acc;
        logic [4:0] obs, expv;
        do_reset();
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        issue_cmd(2'd1, 16'd0, acc);
        for (int k = 1; k <= 4; k++) begin
            obs  = {busy, done, m_tvalid, select_active};
            expv = {k <= 3, k == 4, k == 4, (k >= 3) ? 2'd1 : 2'd0};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL idle_switch_c%0d: busy,done,m_tvalid,sel = %b, want %b", k, obs, expv);
            end
            nxt();
        end
        tests++;
        if (switch_count !== 16'd1 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_switch_end: count %0d done %b, want 1 0", switch_count, done);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_mid_packet();
        int acc;
        int base;
        do_reset();
        m_tready    = 1'b1;
        sel_chg_cyc = -1;
        done_cyc    = -1;
        base        = beats_seen;
        fork
            send_pkt(8, 2'd0, 1'b1);
            begin
                int n = 0;
                while (beats_seen - base < 3 && n < 50) begin
                    nxt();
                    n++;
                end
                issue_cmd(2'd1, 16'd0, acc);
            end
        join
        repeat (5) nxt();
        tests++;
        if (sel_chg_cyc !== tlast_cyc + 2) begin
            fails++;
            $display("FAIL mid_pkt_sel: select changed at cycle %0d, want %0d", sel_chg_cyc, tlast_cyc + 2);
        end
        tests++;
        if (done_cyc !== tlast_cyc + 3 || switch_count !== 16'd1) begin
            fails++;
            $display("FAIL mid_pkt_done: done at %0d count %0d, want %0d 1", done_cyc, switch_count, tlast_cyc + 3);
        end
        send_pkt(2, 2'd1, 1'b1);
        nxt();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL mid_pkt_drain: %0d beats still expected, want 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int         acc;
        logic [5:0] obs, expv;
        do_reset();
        m_tready = 1'b1;
        send_pkt(1, 2'd0, 1'b0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        issue_cmd(2'd1, 16'd5, acc);
        for (int k = 1; k <= 6; k++) begin
            obs  = {busy, err_timeout, done, m_tvalid, select_active};
            expv = {k <= 5, k == 6, 1'b0, 1'b1, 2'd0};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL timeout_c%0d: busy,err_t,done,m_tvalid,sel = %b, want %b", k, obs, expv);
            end
            nxt();
        end
        tests++;
        if (err_timeout !== 1'b0 || switch_count !== 16'd0) begin
            fails++;
            $display("FAIL timeout_end: err_t %b count %0d, want 0 0", err_timeout, switch_count);
        end
        m_tready = 1'b1;
        send_pkt(1, 2'd0, 1'b1);
        m_tready = 1'b0;
    endtask

    task automatic test_timeout_tie();
        int acc;
        do_reset();
        m_tready = 1'b1;
        send_pkt(1, 2'd0, 1'b0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        issue_cmd(2'd1, 16'd2, acc);
        nxt();
        exp_q.push_back(2'd0);
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        nxt();
        tests++;
        if ({err_timeout, done, busy} !== 3'b100 || select_active !== 2'd0) begin
            fails++;
            $display("FAIL tie_timeout: err_t,done,busy %b sel %0d, want 100 0", {err_timeout, done, busy}, select_active);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        issue_cmd(2'd1, 16'd0, acc);
        nxt();
        nxt();
        tests++;
        if (select_active !== 2'd1) begin
            fails++;
            $display("FAIL tie_inpkt_clear: select %0d three cycles after accept, want 1", select_active);
        end
        nxt();
    endtask

    task automatic test_range_noop();
        int acc;
        do_reset();
        issue_cmd(2'd2, 16'd0, acc);
        tests++;
        if ({err_range, busy, done} !== 3'b100 || select_active !== 2'd0 || switch_count !== 16'd0) begin
            fails++;
            $display("FAIL range_pulse: err_r,busy,done %b sel %0d count %0d, want 100 0 0",
                     {err_range, busy, done}, select_active, switch_count);
        end
        nxt();
        tests++;
        if (err_range !== 1'b0) begin
            fails++;
            $display("FAIL range_width: err_range %b second cycle, want 0", err_range);
        end
        issue_cmd(2'd0, 16'd0, acc);
        tests++;
        if ({done, busy, err_range} !== 3'b100 || switch_count !== 16'd0) begin
            fails++;
            $display("FAIL noop_done: done,busy,err_r %b count %0d, want 100 0", {done, busy, err_range}, switch_count);
        end
        nxt();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL noop_end: done %b busy %b, want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] obs, expv;
        do_reset();
        cmd_valid   = 1'b1;
        cmd_select  = 2'd1;
        cmd_timeout = '0;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready0: cmd_ready %b, want 1", cmd_ready);
        end
        nxt();
        cmd_select = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            obs  = {cmd_ready, done};
            expv = {k == 4, k == 4};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL b2b_c%0d: cmd_ready,done = %b, want %b", k, obs, expv);
            end
            if (k < 4) nxt();
        end
        nxt();
        cmd_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: busy %b cmd_ready %b, want 1 0", busy, cmd_ready);
        end
        repeat (3) nxt();
        tests++;
        if (done !== 1'b1 || select_active !== 2'd0 || switch_count !== 16'd2) begin
            fails++;
            $display("FAIL b2b_end: done %b sel %0d count %0d, want 1 0 2", done, select_active, switch_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        int acc;
        do_reset();
        m_tready = 1'b1;
        send_pkt(1, 2'd0, 1'b0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        issue_cmd(2'd1, 16'd0, acc);
        nxt();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_drain_pre: busy %b, want 1", busy);
        end
        done_cyc    = -1;
        axil_areset = 1'b1;
        #1;
        tests++;
        if ({busy, done, err_timeout, err_range, cmd_ready, m_tvalid} !== 6'b000011 ||
            select_active !== 2'd0 || switch_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_drain_async: flags %b sel %0d count %0d, want 000011 0 0",
                     {busy, done, err_timeout, err_range, cmd_ready, m_tvalid}, select_active, switch_count);
        end
        nxt();
        axil_areset = 1'b0;
        s_tvalid    = 1'b0;
        repeat (6) nxt();
        tests++;
        if (select_active !== 2'd0 || switch_count !== 16'd0 || busy !== 1'b0 || done_cyc !== -1) begin
            fails++;
            $display("FAIL rst_drain_after: sel %0d count %0d busy %b done_cyc %0d, want 0 0 0 -1",
                     select_active, switch_count, busy, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_idle_switch();
        test_mid_packet();
        test_timeout();
        test_timeout_tie();
        test_range_noop();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
